// File: rtl/pipelined_control.sv
// Registered ID-stage control decoder with in-flight destination history,
// JR rs-forwarding and load-use bubble insertion. Optional counters: PIPELINED_CONTROL_PERF_EN.
module pipelined_control #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4,
  parameter int HIST_DEPTH = 2,
  parameter int FWD_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  flush,
  output logic                  out_valid,
  output logic                  RegWrite,
  output logic                  MemToReg,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  Branch,
  output logic                  RegDst,
  output logic                  ALUSrc,
  output logic [ALUOP_W-1:0]    ALUOp,
  output logic [1:0]            Jump,
  output logic [FWD_W-1:0]      jr_fwd_sel,
  output logic [REG_ADDR_W-1:0] dest_reg,
`ifdef PIPELINED_CONTROL_PERF_EN
  output logic [31:0]           stall_count,
  output logic [31:0]           fwd_count,
  output logic [31:0]           jr_count,
`endif
  output logic                  illegal
);

  logic                  w_rw, w_m2r, w_mr, w_mw, w_br, w_rdst, w_as, w_ill, w_is_jr;
  logic [ALUOP_W-1:0]    w_alu;
  logic [1:0]            w_jump;
  logic [REG_ADDR_W-1:0] w_dest;
  logic [FWD_W-1:0]      w_fwd;
  logic                  w_found, w_hit_load, w_hazard, w_accept;

  logic [HIST_DEPTH:1]   r_hv;
  logic [HIST_DEPTH:1]   r_hm;
  logic [REG_ADDR_W-1:0] r_hd [1:HIST_DEPTH];

  logic                  r_valid, r_ill;
  logic [6:0]            r_ctl;
  logic [ALUOP_W-1:0]    r_alu;
  logic [1:0]            r_jump;
  logic [FWD_W-1:0]      r_fwd;
  logic [REG_ADDR_W-1:0] r_dest;

  always_comb begin
    w_rw   = 1'b0;
    w_m2r  = 1'b0;
    w_mr   = 1'b0;
    w_mw   = 1'b0;
    w_br   = 1'b0;
    w_rdst = 1'b0;
    w_as   = 1'b0;
    w_ill  = 1'b0;
    w_alu  = '0;
    w_jump = 2'b00;
    w_dest = '0;
    case (opcode)
      6'b000000: begin
        w_rw   = 1'b1;
        w_dest = rd;
        case (funct)
          6'b100000: w_alu = ALUOP_W'(4'b0001);
          6'b100001: w_alu = ALUOP_W'(4'b1010);
          6'b100010: w_alu = ALUOP_W'(4'b0010);
          6'b100011: w_alu = ALUOP_W'(4'b1011);
          6'b100100: w_alu = ALUOP_W'(4'b0011);
          6'b100101: w_alu = ALUOP_W'(4'b0100);
          6'b100111: w_alu = ALUOP_W'(4'b0101);
          6'b101010: w_alu = ALUOP_W'(4'b0110);
          6'b000000: w_alu = ALUOP_W'(4'b0111);
          6'b000010: w_alu = ALUOP_W'(4'b1000);
          6'b000011: w_alu = ALUOP_W'(4'b1001);
          6'b001000: begin
            w_rw   = 1'b0;
            w_dest = '0;
            w_jump = 2'b10;
          end
          default: begin
            w_rw   = 1'b0;
            w_dest = '0;
            w_ill  = 1'b1;
          end
        endcase
      end
      6'b100011: begin
        w_rw   = 1'b1;
        w_m2r  = 1'b1;
        w_mr   = 1'b1;
        w_as   = 1'b1;
        w_rdst = 1'b1;
        w_alu  = ALUOP_W'(4'b0001);
        w_dest = rt;
      end
      6'b101011: begin
        w_mw  = 1'b1;
        w_as  = 1'b1;
        w_alu = ALUOP_W'(4'b0001);
      end
      6'b000100: begin
        w_br  = 1'b1;
        w_alu = ALUOP_W'(4'b0010);
      end
      6'b001000: begin
        w_rw   = 1'b1;
        w_as   = 1'b1;
        w_rdst = 1'b1;
        w_alu  = ALUOP_W'(4'b0001);
        w_dest = rt;
      end
      6'b000010: w_jump = 2'b01;
      default:   w_ill  = 1'b1;
    endcase
  end

  assign w_is_jr = (opcode == 6'b000000) && (funct == 6'b001000);

  // Youngest matching entry wins; a zero destination never matches, so rs=0 always reads the regfile.
  always_comb begin
    w_fwd      = '0;
    w_found    = 1'b0;
    w_hit_load = 1'b0;
    for (int k = 1; k <= HIST_DEPTH; k++) begin
      if (!w_found && r_hv[k] && (r_hd[k] != '0) && (r_hd[k] == rs)) begin
        w_found    = 1'b1;
        w_fwd      = FWD_W'(k);
        w_hit_load = (k == 1) && r_hm[k];
      end
    end
  end

  assign w_hazard = in_valid && w_is_jr && w_hit_load;
  assign in_ready = !w_hazard || flush;
  assign w_accept = in_valid && !flush && !w_hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
      r_ctl   <= '0;
      r_alu   <= '0;
      r_jump  <= '0;
      r_fwd   <= '0;
      r_dest  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ill   <= w_ill;
      r_ctl   <= {w_rw, w_m2r, w_mr, w_mw, w_br, w_rdst, w_as};
      r_alu   <= w_alu;
      r_jump  <= w_jump;
      r_fwd   <= w_is_jr ? w_fwd : '0;
      r_dest  <= w_dest;
    end else begin
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
      r_ctl   <= '0;
      r_alu   <= '0;
      r_jump  <= '0;
      r_fwd   <= '0;
      r_dest  <= '0;
    end
  end

  // History advances every cycle; stalls and idle cycles enter as invalid entries.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_hv <= '0;
      r_hm <= '0;
      for (int k = 1; k <= HIST_DEPTH; k++) r_hd[k] <= '0;
    end else begin
      for (int k = HIST_DEPTH; k >= 2; k--) begin
        r_hv[k] <= r_hv[k-1];
        r_hm[k] <= r_hm[k-1];
        r_hd[k] <= r_hd[k-1];
      end
      r_hv[1] <= w_accept;
      r_hm[1] <= w_accept && w_mr;
      r_hd[1] <= w_accept ? w_dest : '0;
    end
  end

`ifdef PIPELINED_CONTROL_PERF_EN
  logic [31:0] r_stall_cnt, r_fwd_cnt, r_jr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
      r_jr_cnt    <= '0;
    end else begin
      if (w_hazard && !flush) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_accept && w_is_jr) r_jr_cnt <= r_jr_cnt + 32'd1;
      if (w_accept && w_is_jr && (w_fwd != '0)) r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign fwd_count   = r_fwd_cnt;
  assign jr_count    = r_jr_cnt;
`endif

  assign out_valid  = r_valid;
  assign illegal    = r_ill;
  assign {RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc} = r_ctl;
  assign ALUOp      = r_alu;
  assign Jump       = r_jump;
  assign jr_fwd_sel = r_fwd;
  assign dest_reg   = r_dest;

endmodule

// File: tb/tb_pipelined_control.sv
// Bench for pipelined_control: decode vector table plus hazard/flush/reset sequences,
// expected output words queued at drive time and compared one cycle later.
module tb_pipelined_control;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, flush;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       in_ready, out_valid, RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc;
  logic [3:0] ALUOp;
  logic [1:0] Jump;
  logic [2:0] jr_fwd_sel;
  logic [4:0] dest_reg;
  logic       illegal;
`ifdef PIPELINED_CONTROL_PERF_EN
  logic [31:0] stall_count, fwd_count, jr_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_control dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .flush(flush),
    .out_valid(out_valid), .RegWrite(RegWrite), .MemToReg(MemToReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .Jump(Jump), .jr_fwd_sel(jr_fwd_sel), .dest_reg(dest_reg),
`ifdef PIPELINED_CONTROL_PERF_EN
    .stall_count(stall_count), .fwd_count(fwd_count), .jr_count(jr_count),
`endif
    .illegal(illegal)
  );

  // {out_valid, RegWrite,MemToReg,MemRead,MemWrite,Branch,RegDst,ALUSrc, ALUOp, Jump, fwd, dest, illegal}
  logic [22:0] w_act;
  assign w_act = {out_valid, RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc,
                  ALUOp, Jump, jr_fwd_sel, dest_reg, illegal};

  typedef struct packed {
    logic        iv, fl, rn;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic        rdy;
    logic [22:0] exp;
  } vec_t;

  localparam logic [6:0] RW = 7'b1000000;
  localparam logic [5:0] JR = 6'b001000;
  localparam logic [22:0] BUB = 23'd0;

  logic [22:0] sb [$];
  vec_t tbl [27];

  function automatic logic [22:0] ex(input logic ov, input logic [6:0] ctl, input logic [3:0] alu,
                                     input logic [1:0] jmp, input logic [2:0] fwd,
                                     input logic [4:0] dst, input logic ill);
    return {ov, ctl, alu, jmp, fwd, dst, ill};
  endfunction

  function automatic vec_t mk(input logic iv, input logic fl, input logic rn, input logic [5:0] op,
                              input logic [5:0] fn, input logic [4:0] rs_i, input logic [4:0] rt_i,
                              input logic [4:0] rd_i, input logic rdy, input logic [22:0] e);
    vec_t v;
    v.iv = iv; v.fl = fl; v.rn = rn; v.op = op; v.fn = fn;
    v.rs = rs_i; v.rt = rt_i; v.rd = rd_i; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs_i,
                               input logic [4:0] rt_i, input logic [4:0] rd_i, input logic [22:0] e);
    return mk(1'b1, 1'b0, 1'b1, op, fn, rs_i, rt_i, rd_i, 1'b1, e);
  endfunction

  task automatic step(input vec_t t, input string nm);
    logic [22:0] e;
    in_valid = t.iv; flush = t.fl; rst_n = t.rn;
    opcode = t.op; funct = t.fn; rs = t.rs; rt = t.rt; rd = t.rd;
    #3;
    checks++;
    if (in_ready !== t.rdy) begin
      errors++;
      $display("FAIL %s in_ready: got %b want %b", nm, in_ready, t.rdy);
    end
    sb.push_back(t.exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (w_act !== e) begin
      errors++;
      $display("FAIL %s outputs: got %h want %h", nm, w_act, e);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  vec_t rst_v;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0;
    rst_v = mk(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1, BUB);

    tbl[0]  = mkv(6'b000000, 6'b100000, 5'd0, 5'd0, 5'd3,  ex(1, RW, 4'b0001, 2'b00, 3'd0, 5'd3, 0));
    tbl[1]  = mkv(6'b000000, 6'b100001, 5'd0, 5'd0, 5'd1,  ex(1, RW, 4'b1010, 2'b00, 3'd0, 5'd1, 0));
    tbl[2]  = mkv(6'b000000, 6'b100010, 5'd0, 5'd0, 5'd2,  ex(1, RW, 4'b0010, 2'b00, 3'd0, 5'd2, 0));
    tbl[3]  = mkv(6'b000000, 6'b100011, 5'd0, 5'd0, 5'd3,  ex(1, RW, 4'b1011, 2'b00, 3'd0, 5'd3, 0));
    tbl[4]  = mkv(6'b000000, 6'b100100, 5'd0, 5'd0, 5'd4,  ex(1, RW, 4'b0011, 2'b00, 3'd0, 5'd4, 0));
    tbl[5]  = mkv(6'b000000, 6'b100101, 5'd0, 5'd0, 5'd5,  ex(1, RW, 4'b0100, 2'b00, 3'd0, 5'd5, 0));
    tbl[6]  = mkv(6'b000000, 6'b100111, 5'd0, 5'd0, 5'd6,  ex(1, RW, 4'b0101, 2'b00, 3'd0, 5'd6, 0));
    tbl[7]  = mkv(6'b000000, 6'b101010, 5'd0, 5'd0, 5'd7,  ex(1, RW, 4'b0110, 2'b00, 3'd0, 5'd7, 0));
    tbl[8]  = mkv(6'b000000, 6'b000000, 5'd0, 5'd0, 5'd8,  ex(1, RW, 4'b0111, 2'b00, 3'd0, 5'd8, 0));
    tbl[9]  = mkv(6'b000000, 6'b000010, 5'd0, 5'd0, 5'd9,  ex(1, RW, 4'b1000, 2'b00, 3'd0, 5'd9, 0));
    tbl[10] = mkv(6'b000000, 6'b000011, 5'd0, 5'd0, 5'd10, ex(1, RW, 4'b1001, 2'b00, 3'd0, 5'd10, 0));
    tbl[11] = mkv(6'b100011, 6'b000000, 5'd1, 5'd11, 5'd0, ex(1, 7'b1110011, 4'b0001, 2'b00, 3'd0, 5'd11, 0));
    tbl[12] = mkv(6'b101011, 6'b000000, 5'd1, 5'd12, 5'd0, ex(1, 7'b0001001, 4'b0001, 2'b00, 3'd0, 5'd0, 0));
    tbl[13] = mkv(6'b000100, 6'b000000, 5'd1, 5'd2,  5'd0, ex(1, 7'b0000100, 4'b0010, 2'b00, 3'd0, 5'd0, 0));
    tbl[14] = mkv(6'b001000, 6'b000000, 5'd1, 5'd13, 5'd0, ex(1, 7'b1000011, 4'b0001, 2'b00, 3'd0, 5'd13, 0));
    tbl[15] = mkv(6'b000010, 6'b000000, 5'd0, 5'd0,  5'd0, ex(1, 7'b0, 4'b0000, 2'b01, 3'd0, 5'd0, 0));
    tbl[16] = mkv(6'b111111, 6'b000000, 5'd0, 5'd0,  5'd0, ex(1, 7'b0, 4'b0000, 2'b00, 3'd0, 5'd0, 1));
    tbl[17] = mkv(6'b000000, 6'b111111, 5'd0, 5'd0,  5'd9, ex(1, 7'b0, 4'b0000, 2'b00, 3'd0, 5'd0, 1));
    tbl[18] = mkv(6'b000000, 6'b100000, 5'd0, 5'd0,  5'd5, ex(1, RW, 4'b0001, 2'b00, 3'd0, 5'd5, 0));
    tbl[19] = mkv(6'b000000, JR,        5'd5, 5'd0,  5'd0, ex(1, 7'b0, 4'b0000, 2'b10, 3'd1, 5'd0, 0));
    tbl[20] = mkv(6'b000000, JR,        5'd5, 5'd0,  5'd0, ex(1, 7'b0, 4'b0000, 2'b10, 3'd2, 5'd0, 0));
    tbl[21] = mkv(6'b000000, 6'b100000, 5'd0, 5'd0,  5'd4, ex(1, RW, 4'b0001, 2'b00, 3'd0, 5'd4, 0));
    tbl[22] = mkv(6'b000000, 6'b100000, 5'd0, 5'd0,  5'd4, ex(1, RW, 4'b0001, 2'b00, 3'd0, 5'd4, 0));
    tbl[23] = mkv(6'b000000, JR,        5'd4, 5'd0,  5'd0, ex(1, 7'b0, 4'b0000, 2'b10, 3'd1, 5'd0, 0));
    tbl[24] = mkv(6'b000000, 6'b100000, 5'd0, 5'd0,  5'd0, ex(1, RW, 4'b0001, 2'b00, 3'd0, 5'd0, 0));
    tbl[25] = mkv(6'b000000, JR,        5'd0, 5'd0,  5'd0, ex(1, 7'b0, 4'b0000, 2'b10, 3'd0, 5'd0, 0));
    tbl[26] = mkv(6'b000000, 6'b000000, 5'd0, 5'd0,  5'd0, ex(1, RW, 4'b0111, 2'b00, 3'd0, 5'd0, 0));

    @(posedge clk);
    #1;
    step(rst_v, "reset_idle");
    step(mk(1, 0, 0, 6'b000000, 6'b100000, 5'd0, 5'd0, 5'd3, 1'b1, BUB), "reset_with_instr");

    for (int i = 0; i < 27; i++) step(tbl[i], $sformatf("vec%0d", i));

    step(mk(0, 0, 1, 6'b100011, 6'b000000, 5'd0, 5'd7, 5'd0, 1'b1, BUB), "idle_bubble");

    // load-use: one bubble, then JR forwards from entry 2
    step(rst_v, "reset_before_lu");
    step(mkv(6'b100011, 6'd0, 5'd1, 5'd7, 5'd0, ex(1, 7'b1110011, 4'b0001, 2'b00, 3'd0, 5'd7, 0)), "lu_load");
    step(mk(1, 0, 1, 6'b000000, JR, 5'd7, 5'd0, 5'd0, 1'b0, BUB), "lu_stall");
    step(mkv(6'b000000, JR, 5'd7, 5'd0, 5'd0, ex(1, 7'b0, 4'b0000, 2'b10, 3'd2, 5'd0, 0)), "lu_issue");
`ifdef PIPELINED_CONTROL_PERF_EN
    chk32("stall_count_lu", stall_count, 32'd1);
    chk32("jr_count_lu", jr_count, 32'd1);
    chk32("fwd_count_lu", fwd_count, 32'd1);
`endif

    // flush alongside JR drops it and clears history
    step(mkv(6'b000000, 6'b100000, 5'd0, 5'd0, 5'd9, ex(1, RW, 4'b0001, 2'b00, 3'd0, 5'd9, 0)), "fl_add");
    step(mk(1, 1, 1, 6'b000000, JR, 5'd9, 5'd0, 5'd0, 1'b1, BUB), "fl_jr");
    step(mkv(6'b000000, JR, 5'd9, 5'd0, 5'd0, ex(1, 7'b0, 4'b0000, 2'b10, 3'd0, 5'd0, 0)), "fl_replay");

    // flush dominates a load-use hazard
    step(mkv(6'b100011, 6'd0, 5'd1, 5'd7, 5'd0, ex(1, 7'b1110011, 4'b0001, 2'b00, 3'd0, 5'd7, 0)), "flh_load");
    step(mk(1, 1, 1, 6'b000000, JR, 5'd7, 5'd0, 5'd0, 1'b1, BUB), "flh_jr");
    step(mkv(6'b000000, JR, 5'd7, 5'd0, 5'd0, ex(1, 7'b0, 4'b0000, 2'b10, 3'd0, 5'd0, 0)), "flh_replay");
`ifdef PIPELINED_CONTROL_PERF_EN
    chk32("stall_count_fl", stall_count, 32'd1);
    chk32("jr_count_fl", jr_count, 32'd3);
    chk32("fwd_count_fl", fwd_count, 32'd1);
`endif

    // reset during a stall aborts it
    step(mkv(6'b100011, 6'd0, 5'd1, 5'd7, 5'd0, ex(1, 7'b1110011, 4'b0001, 2'b00, 3'd0, 5'd7, 0)), "rs_load");
    step(mk(1, 0, 0, 6'b000000, JR, 5'd7, 5'd0, 5'd0, 1'b0, BUB), "rs_stall_reset");
    step(mkv(6'b000000, JR, 5'd7, 5'd0, 5'd0, ex(1, 7'b0, 4'b0000, 2'b10, 3'd0, 5'd0, 0)), "rs_replay");
`ifdef PIPELINED_CONTROL_PERF_EN
    chk32("stall_count_rs", stall_count, 32'd0);
    chk32("jr_count_rs", jr_count, 32'd1);
    chk32("fwd_count_rs", fwd_count, 32'd0);
`endif

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
- Registered, hazard-aware successor to the combinational main decoder; sits between the IF/ID register and the ID/EX register of the MIPS pipeline.
- Decodes opcode/funct into the control word and keeps a parametrised history of in-flight destination registers.
- Resolves JR rs-forwarding against any history entry, not only the previous rd, and inserts load-use bubbles.
- Drives the control fields of ID/EX directly.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- ALUOP_W, 4, ALUOp width.
- HIST_DEPTH, 2, number of tracked in-flight instructions (entry 1 = most recent); legal range 1..7.
- FWD_W, 3, width of jr_fwd_sel; must satisfy 2^FWD_W > HIST_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  instruction presented.
- in_ready  out  1  instruction accepted this cycle (combinational).
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- rs, rt, rd  in  REG_ADDR_W each  register specifiers.
- flush  in  1  squash: discard the presented instruction and clear history.
- out_valid  out  1  registered control word is a real instruction.
- RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc  out  1 each  control signals; RegDst 0 selects rd, 1 selects rt.
- ALUOp  out  ALUOP_W  ALU operation.
- Jump  out  2  00 none, 01 J, 10 JR.
- jr_fwd_sel  out  FWD_W  0 = register file, k = forward from history entry k.
- dest_reg  out  REG_ADDR_W  destination of the registered instruction (0 if none).
- illegal  out  1  one-cycle pulse: undecodable instruction accepted.

Behaviour:
- All outputs are registered, latency 1 cycle from acceptance.
- Reset (rst_n=0 at a clk edge): every output 0, all history entries invalid; in_ready follows the combinational rule below.
- R-type (opcode 0): RegWrite=1, RegDst=0. ALUOp by funct: ADD 100000→0001, ADDU 100001→1010, SUB 100010→0010, SUBU 100011→1011, AND 100100→0011, OR 100101→0100, NOR 100111→0101, SLT 101010→0110, SLL/NOP 000000→0111, SRL 000010→1000, SRA 000011→1001.
- JR (funct 001000): RegWrite=0, Jump=10.
- LW 100011: RegWrite, MemToReg, MemRead, ALUSrc, RegDst=1, ALUOp 0001.
- SW 101011: MemWrite, ALUSrc, ALUOp 0001.
- BEQ 000100: Branch, ALUOp 0010.
- ADDI 001000: RegWrite, ALUSrc, RegDst=1, ALUOp 0001.
- J 000010: Jump=01.
- Any other opcode/funct: bubble outputs with out_valid=1 and illegal=1.
- dest_reg: rd for R-type with RegWrite, rt for LW/ADDI, otherwise 0.
- History is a shift register of {valid, dest_reg, MemRead}. It shifts every cycle the stage advances; a bubble shifts in as invalid. Entries with dest 0 never match.
- JR forwarding: jr_fwd_sel = smallest k with a valid entry k whose dest equals rs; 0 if there is no match or rs=0.
- Load-use hazard:
  - Condition: in_valid, JR, and the matching entry is entry 1 with MemRead=1.
  - Response: in_ready=0; a bubble is registered (out_valid=0, all controls 0) and shifts into history.
  - Upstream holds the instruction. Next cycle the load sits in entry 2, the hazard clears, and JR issues with jr_fwd_sel=2.
  - Exactly one bubble per load-use.
- in_ready = !hazard || flush.
- in_valid=0: registered outputs become a bubble.
- flush:
  - Dominates in_valid and hazard.
  - The presented instruction is dropped, the next outputs are a bubble, and all history entries are invalidated on that edge.
  - rst_n=0 dominates flush.
- Reset mid-stall: the stall aborts and history clears.

Optional Feature:
- Macro: PIPELINED_CONTROL_PERF_EN.
- Enabled: adds out ports stall_count[31:0], fwd_count[31:0] and jr_count[31:0].
  - stall_count increments per load-use bubble.
  - fwd_count increments per accepted JR with jr_fwd_sel≠0.
  - jr_count increments per accepted JR.
  - All three are zeroed by reset, wrap modulo 2^32, and are not cleared by flush.
- Disabled: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then ADD (funct 100000, rd=3) → next cycle RegWrite=1, ALUOp=0001, dest_reg=3, out_valid=1, Jump=00.
- ADD rd=5, then JR rs=5 → JR cycle outputs Jump=10, jr_fwd_sel=1; with an unrelated instruction in between → jr_fwd_sel=2.
- LW rt=7, then JR rs=7 → in_ready=0 for one cycle with a bubble out; following cycle Jump=10, jr_fwd_sel=2; stall_count=1 when the macro is defined.
- ADD rd=4, ADD rd=4, then JR rs=4 → jr_fwd_sel=1 (most recent match wins); JR rs=0 after ADD rd=0 → jr_fwd_sel=0.
- ADD rd=9, flush asserted alongside JR rs=9 → bubble out, history cleared; JR re-presented → jr_fwd_sel=0.
- opcode 111111 → illegal=1 for one cycle with all controls 0; rst_n=0 during a load-use stall → all outputs 0 next cycle, in_ready=1.
